// File: rtl/uart_ctl_if.sv
// Data-bus slave port of uart_ctl: byte address, qualified write strobe,
// write data from the master and registered read data back to it.
// The master's write data is carried as dout because 'do' is a reserved word.
interface uart_ctl_if;
    logic [15:0] a;
    logic        we;
    logic [15:0] dout;
    logic [15:0] di;

    modport master (output a, output we, output dout, input di);
    modport slave  (input a, input we, input dout, output di);
endinterface

// File: rtl/uart_ctl.sv
// uart_ctl: memory-mapped UART with a TX FIFO and a single-byte RX holding
// register. Register map by a[2:1]: DATA, STATUS, DIVISOR, CTRL.
// Optional receiver: built only when the macro UART_RX_EN is defined;
// otherwise uart_rx is ignored and all RX status reads as zero.
module uart_ctl #(
    parameter logic [15:0] CLK_DIV_DEFAULT = 16'd867,
    parameter int unsigned TX_DEPTH_LOG2   = 3
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    uart_ctl_if.slave bus,
    input  logic      uart_rx,
    output logic      uart_tx,
    output logic      irq
);
    localparam int unsigned DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int unsigned CNT_W = TX_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ---------------- reset release synchroniser ----------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Assert immediately, release after two sys_clk edges
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    always_comb rst_n = rst_sync_q[1];

    // ---------------- register decode ----------------
    logic [1:0] reg_sel;
    logic       wr_data, wr_stat, wr_div, wr_ctrl;
    logic       unused_addr;

    // Only a[2:1] selects a register
    always_comb begin
        reg_sel     = bus.a[2:1];
        wr_data     = bus.we && (reg_sel == 2'd0);
        wr_stat     = bus.we && (reg_sel == 2'd1);
        wr_div      = bus.we && (reg_sel == 2'd2);
        wr_ctrl     = bus.we && (reg_sel == 2'd3);
        unused_addr = ^{bus.a[15:3], bus.a[0]};
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]               fifo_mem [DEPTH];
    logic [TX_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     tx_full, tx_empty, push, tx_pop;
    logic [7:0]               fifo_rdata;

    // A push while full is accepted only when a pop frees a slot the same cycle
    always_comb begin
        tx_full    = (count_q == CNT_W'(DEPTH));
        tx_empty   = (count_q == '0);
        push       = wr_data && (!tx_full || tx_pop);
        fifo_rdata = fifo_mem[rd_ptr_q];
    end

    // FIFO storage (no reset; validity is tracked by the pointers)
    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.dout[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + TX_DEPTH_LOG2'(1);
            if (tx_pop) rd_ptr_q <= rd_ptr_q + TX_DEPTH_LOG2'(1);
            case ({push, tx_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, tx_busy;
    logic [15:0] div_q;

    // TX state, bit timer, shifter and registered line driver
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // TX next state; divisor is latched at each frame start; line follows next state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_rdata;
                    tx_div_d   = div_q;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == tx_div_q) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == tx_div_q) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == tx_div_q) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_rdata;
                        tx_div_d   = div_q;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        tx_busy = (tx_state_q != TX_IDLE);
        uart_tx = tx_q;
    end

    // ---------------- RX engine ----------------
    logic       rx_valid, rx_overrun, rx_frame_err;
    logic [7:0] rx_hold;

`ifdef UART_RX_EN
    localparam logic [1:0] CTRL_WMASK = 2'b11;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done_ok, rx_done_err;
    logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
    logic        rx_ferr_q, rx_ferr_d;
    logic [7:0]  rx_hold_q, rx_hold_d;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_comb rx_half = 16'(({1'b0, rx_div_q} + 17'd1) >> 1);

    // RX state, bit timer and shifter
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: half-bit into START, then one sample per bit period
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 16'd1;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done_ok  = 1'b0;
        rx_done_err = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_div_d   = div_q;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == rx_half) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_done_ok  = rx_s2_q;
                    rx_done_err = !rx_s2_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Sticky RX flags: W1C applied before new events so a same-cycle clear
    // and byte completion leaves the new byte valid
    always_comb begin
        rx_valid_d   = rx_valid_q   & ~(wr_stat & bus.dout[2]);
        rx_overrun_d = rx_overrun_q & ~(wr_stat & bus.dout[3]);
        rx_ferr_d    = rx_ferr_q    & ~(wr_stat & bus.dout[4]);
        rx_hold_d    = rx_hold_q;
        if (rx_done_ok) begin
            if (!rx_valid_d) begin
                rx_hold_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end
        if (rx_done_err) rx_ferr_d = 1'b1;
    end

    // RX holding register and sticky flag storage
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_hold_q    <= '0;
        end else begin
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_hold_q    <= rx_hold_d;
        end
    end

    always_comb begin
        rx_valid     = rx_valid_q;
        rx_overrun   = rx_overrun_q;
        rx_frame_err = rx_ferr_q;
        rx_hold      = rx_hold_q;
    end
`else
    localparam logic [1:0] CTRL_WMASK = 2'b10;

    logic unused_rx;

    // Receiver absent: status and data read as zero
    always_comb begin
        rx_valid     = 1'b0;
        rx_overrun   = 1'b0;
        rx_frame_err = 1'b0;
        rx_hold      = '0;
        unused_rx    = uart_rx;
    end
`endif

    // ---------------- registers, read path, interrupt ----------------
    logic [1:0]  ctrl_q;
    logic        tx_drop_q, tx_drop_d, irq_q, irq_d;
    logic [15:0] di_q, rd_d;

    // Next values for read data, drop flag and interrupt
    always_comb begin
        tx_drop_d = (tx_drop_q & ~(wr_stat & bus.dout[5])) | (wr_data & tx_full & ~tx_pop);
        irq_d     = (ctrl_q[0] & rx_valid) | (ctrl_q[1] & tx_empty & ~tx_busy);
        case (reg_sel)
            2'd0:    rd_d = {8'h00, rx_hold};
            2'd1:    rd_d = {9'd0, tx_busy, tx_drop_q, rx_frame_err, rx_overrun,
                             rx_valid, tx_empty, tx_full};
            2'd2:    rd_d = div_q;
            default: rd_d = {14'd0, ctrl_q};
        endcase
    end

    // Control registers, registered read data and interrupt
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= CLK_DIV_DEFAULT;
            ctrl_q    <= '0;
            tx_drop_q <= 1'b0;
            di_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_div)  div_q  <= bus.dout;
            if (wr_ctrl) ctrl_q <= bus.dout[1:0] & CTRL_WMASK;
            tx_drop_q <= tx_drop_d;
            di_q      <= rd_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        bus.di = di_q;
        irq    = irq_q;
    end
endmodule

// File: tb/tb_uart_ctl.sv
// Directed self-checking bench for uart_ctl: register reset values, TX frame
// shape and timing, FIFO fill/drop with contiguous frames, RX receive paths
// (or their absence when the receiver is not built) and mid-frame reset.
module tb_uart_ctl;
    logic clk     = 1'b0;
    logic sys_rst = 1'b0;
    logic rx_line = 1'b1;
    logic tx_line;
    logic irq;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    uart_ctl_if bus ();

    uart_ctl #(
        .CLK_DIV_DEFAULT(16'd867),
        .TX_DEPTH_LOG2  (3)
    ) dut (
        .sys_clk(clk),
        .sys_rst(sys_rst),
        .bus    (bus),
        .uart_rx(rx_line),
        .uart_tx(tx_line),
        .irq    (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] idx, input logic [15:0] data);
        bus.a    = {13'd0, idx, 1'b0};
        bus.we   = 1'b1;
        bus.dout = data;
        step(1);
        bus.we   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [15:0] exp);
        bus.a  = {13'd0, idx, 1'b0};
        bus.we = 1'b0;
        step(1);
        chk(tag, bus.di, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int unsigned j);
        if (j == 0)      return 1'b0;
        else if (j <= 8) return b[3'(j - 1)];
        else             return 1'b1;
    endfunction

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int unsigned p);
        for (int unsigned j = 0; j < 10; j++) begin
            rx_line = (j == 9) ? stop_bit : frame_bit(b, j);
            step(p);
        end
        rx_line = 1'b1;
    endtask

    logic [7:0]  burst [10];
    logic [7:0]  pat;
    int unsigned c0, rel, r2, f, j;

    initial begin
        bus.a    = '0;
        bus.we   = 1'b0;
        bus.dout = '0;
        burst = '{8'hA5, 8'h3C, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h96, 8'h77};

        // Reset state
        step(3);
        chk("rst uart_tx", {15'd0, tx_line}, 16'd1);
        chk("rst irq", {15'd0, irq}, 16'd0);
        chk("rst di", bus.di, 16'h0000);
        sys_rst = 1'b1;
        step(4);
        rd_chk("rst STATUS", 2'd1, 16'h0002);
        rd_chk("rst DIVISOR", 2'd2, 16'd867);
        rd_chk("rst CTRL", 2'd3, 16'h0000);
        rd_chk("rst DATA", 2'd0, 16'h0000);

        // Single frame 0x55 at DIVISOR=3 with tx interrupt enabled
        wr(2'd2, 16'd3);
        wr(2'd3, 16'h0002);
        step(2);
        chk("irq tx idle", {15'd0, irq}, 16'd1);
        pat = 8'h55;
        wr(2'd0, {8'h00, pat});
        step(1);
        for (int unsigned k = 0; k < 42; k++) begin
            if (k > 0) step(1);
            chk($sformatf("tx55 line k=%0d", k), {15'd0, tx_line}, {15'd0, frame_bit(pat, k / 4)});
            chk($sformatf("tx55 irq k=%0d", k), {15'd0, irq}, (k >= 41) ? 16'd1 : 16'd0);
        end
        rd_chk("tx55 STATUS after", 2'd1, 16'h0002);

        // Ten back-to-back writes at DIVISOR=867: nine accepted, tenth dropped
        wr(2'd3, 16'h0000);
        wr(2'd2, 16'd867);
        wr(2'd0, {8'h00, burst[0]});
        c0 = cyc;
        for (int unsigned i = 1; i < 10; i++) wr(2'd0, {8'h00, burst[i]});
        rd_chk("burst STATUS full+drop", 2'd1, 16'h0061);
        wr(2'd2, 16'd3);
        rd_chk("burst DIVISOR mid-frame", 2'd2, 16'd3);
        for (int unsigned g = 0; g < 9100; g++) begin
            rel = cyc - (c0 + 1);
            if (rel >= 9002) break;
            if (rel < 8680) begin
                j = rel / 868;
                if (rel % 868 == 434)
                    chk($sformatf("burst f0 bit%0d", j), {15'd0, tx_line}, {15'd0, frame_bit(burst[0], j)});
            end else if (rel < 9000) begin
                r2 = rel - 8680;
                f  = 1 + r2 / 40;
                j  = (r2 % 40) / 4;
                if (r2 % 40 == 0)
                    chk($sformatf("burst f%0d start edge", f), {15'd0, tx_line}, 16'd0);
                if (r2 % 4 == 2)
                    chk($sformatf("burst f%0d bit%0d", f, j), {15'd0, tx_line}, {15'd0, frame_bit(burst[f], j)});
            end else begin
                chk("burst idle after", {15'd0, tx_line}, 16'd1);
            end
            step(1);
        end
        rd_chk("burst STATUS drained", 2'd1, 16'h0022);
        wr(2'd1, 16'h0020);
        rd_chk("tx_drop W1C", 2'd1, 16'h0002);

`ifdef UART_RX_EN
        // Receive path at DIVISOR=7 (8 cycles per bit)
        wr(2'd2, 16'd7);
        wr(2'd3, 16'h0001);
        send_rx(8'hA3, 1'b1, 8);
        step(4);
        rd_chk("rx STATUS valid", 2'd1, 16'h0006);
        rd_chk("rx DATA A3", 2'd0, 16'h00A3);
        chk("rx irq", {15'd0, irq}, 16'd1);
        send_rx(8'h5C, 1'b1, 8);
        step(4);
        rd_chk("rx STATUS overrun", 2'd1, 16'h000E);
        rd_chk("rx DATA kept", 2'd0, 16'h00A3);
        wr(2'd1, 16'h000C);
        rd_chk("rx W1C valid+ovr", 2'd1, 16'h0002);
        chk("rx irq cleared", {15'd0, irq}, 16'd0);
        rx_line = 1'b0;
        step(2);
        rx_line = 1'b1;
        step(20);
        rd_chk("rx false start", 2'd1, 16'h0002);
        send_rx(8'h3C, 1'b0, 8);
        step(4);
        rd_chk("rx frame err", 2'd1, 16'h0012);
        rd_chk("rx frame err DATA", 2'd0, 16'h00A3);
        wr(2'd1, 16'h0010);
        rd_chk("rx frame err W1C", 2'd1, 16'h0002);
        wr(2'd3, 16'h0000);
`else
        // Receiver not built: line activity and ie_rx have no effect
        wr(2'd2, 16'd7);
        wr(2'd3, 16'h0003);
        rd_chk("norx CTRL", 2'd3, 16'h0002);
        send_rx(8'hA3, 1'b1, 8);
        step(4);
        rd_chk("norx STATUS", 2'd1, 16'h0002);
        rd_chk("norx DATA", 2'd0, 16'h0000);
        chk("norx irq tx only", {15'd0, irq}, 16'd1);
        wr(2'd3, 16'h0000);
`endif

        // Reset in the middle of data bit 4 with bytes still queued
        wr(2'd3, 16'h0002);
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0000);
        wr(2'd0, 16'h0011);
        wr(2'd0, 16'h0022);
        step(20);
        chk("midrst bit4 low", {15'd0, tx_line}, 16'd0);
        sys_rst = 1'b0;
        #1;
        chk("midrst uart_tx", {15'd0, tx_line}, 16'd1);
        chk("midrst irq", {15'd0, irq}, 16'd0);
        chk("midrst di", bus.di, 16'h0000);
        step(3);
        sys_rst = 1'b1;
        step(4);
        rd_chk("midrst STATUS", 2'd1, 16'h0002);
        rd_chk("midrst DIVISOR", 2'd2, 16'd867);
        rd_chk("midrst CTRL", 2'd3, 16'h0000);
        step(10);
        chk("midrst queue lost", {15'd0, tx_line}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_ctl.md
UART_CTL -- requirements
Module: uart_ctl

Interface
REQ-001 SHALL have parameter CLK_DIV_DEFAULT, default 867, reset value of DIVISOR (100 MHz / 115200 baud, minus 1).
REQ-002 SHALL have parameter TX_DEPTH_LOG2, default 3, giving a TX FIFO depth of 2^TX_DEPTH_LOG2 bytes.
REQ-003 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 sys_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 a  in  16  byte address from the data-bus slave port; only a[2:1] decoded.
REQ-006 we  in  1  write strobe, already qualified by the bus decoder for this slave.
REQ-007 do  in  16  write data from the master.
REQ-008 di  out  16  registered read data to the master.
REQ-009 uart_rx  in  1  serial input, idle high, asynchronous to sys_clk.
REQ-010 uart_tx  out  1  serial output, idle high.
REQ-011 irq  out  1  level interrupt.

Function
REQ-012 SHALL use register map by a[2:1]: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL.
REQ-013 SHALL return di = register selected by a, one cycle after a is presented; reads have no side effects.
REQ-014 DATA write SHALL push do[7:0] into the TX FIFO; a write while full SHALL be dropped and set STATUS.tx_drop.
REQ-015 DATA read SHALL return {8'h00, rx_hold}.
REQ-016 STATUS SHALL be: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun, bit4 rx_frame_err, bit5 tx_drop, bit6 tx_busy, others 0.
REQ-017 STATUS write SHALL clear each of bits 2-5 whose do bit is 1 (write-1-to-clear); other bits are read-only.
REQ-018 DIVISOR SHALL be 16-bit clocks-per-bit minus 1; a write SHALL take effect at the next TX/RX frame start, not mid-frame.
REQ-019 CTRL SHALL be: bit0 ie_rx, bit1 ie_tx; irq = (ie_rx & rx_valid) | (ie_tx & tx_empty & ~tx_busy), registered.
REQ-020 TX FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when the FIFO is non-empty, popping one byte on the same cycle.
REQ-021 TX SHALL output each of START (0), 8 data bits LSB first, and STOP (1) for exactly DIVISOR+1 cycles, then return to IDLE or go directly to START if the FIFO is non-empty (no idle gap).
REQ-022 tx_busy SHALL be 1 in every state except IDLE.
REQ-023 A simultaneous push and pop at the FIFO SHALL both succeed; the count is unchanged; a push when full with a same-cycle pop SHALL be accepted.
REQ-024 FIFO pointers SHALL wrap modulo depth; the count SHALL be TX_DEPTH_LOG2+1 bits.
REQ-025 RX SHALL double-flop synchronise uart_rx before any use.
REQ-026 RX FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on a synchronised falling edge.
REQ-027 RX SHALL sample at mid-bit ((DIVISOR+1)/2 cycles into START, then every DIVISOR+1 cycles).
REQ-028 A high level at the mid-START sample SHALL return RX to IDLE with no flag set (false start).
REQ-029 A STOP sample of 0 SHALL set rx_frame_err, discard the byte, and return RX to IDLE.
REQ-030 On a valid byte while rx_valid=0, SHALL load rx_hold and set rx_valid.
REQ-031 On a valid byte while rx_valid=1, SHALL keep rx_hold, drop the new byte, and set rx_overrun.
REQ-032 A same-cycle W1C clear of rx_valid and a new-byte completion SHALL result in rx_valid=1 holding the new byte.

Reset
REQ-033 sys_rst=0 SHALL immediately force: uart_tx=1, di=0, irq=0, both FSMs IDLE, FIFO empty, rx_hold=0, STATUS sticky bits 0, CTRL=0, DIVISOR=CLK_DIV_DEFAULT.
REQ-034 Reset mid-frame SHALL abort the frame; uart_tx=1 in the same cycle; queued bytes are lost.
REQ-035 Reset deassertion SHALL be synchronised internally to sys_clk with a 2-flop release.

Configuration
REQ-036 Macro UART_RX_EN defined: the receiver is built as specified.
REQ-037 UART_RX_EN undefined: no RX logic; uart_rx is ignored; DATA reads 0; STATUS bits 2-4 and ie_rx read 0; irq depends only on the TX term.

Verification
REQ-038 DIVISOR=3, write DATA=0x55 -> uart_tx: 4 cycles 0, bits 1,0,1,0,1,0,1,0 for 4 cycles each, 4 cycles 1; tx_busy high for 40 cycles.
REQ-039 With TX_DEPTH_LOG2=3, write 10 bytes back-to-back while DIVISOR=867 -> first 9 accepted (1 in shift, 8 queued), 10th sets tx_drop; frames are contiguous with no idle gap.
REQ-040 Drive uart_rx frame 0xA3 at DIVISOR=7 -> rx_valid=1, DATA reads 0x00A3; a second frame before clearing sets rx_overrun with DATA still 0x00A3.
REQ-041 A low pulse on uart_rx of 2 cycles at DIVISOR=7 -> RX returns to IDLE; no STATUS change.
REQ-042 Frame with STOP=0 -> rx_frame_err=1, rx_valid=0; writing STATUS=0x0010 -> rx_frame_err=0.
REQ-043 Assert sys_rst mid-TX bit 4 -> uart_tx=1 the same cycle, STATUS reads 0x0002 after release, DIVISOR reads 867.
